// File: rtl/mux_pkg.sv
// Shared types for the round-robin select arbiter.
// Holds the select type, FSM state enum and channel count.
package mux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_sel_arbiter_pick.sv
// Rotating-priority search: first set request above last, with wrap.
// Purely combinational; any flags that at least one request is set.
module rr_pick
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  sel_t              last,
    output sel_t              winner,
    output logic              any
);

    sel_t w_idx;
    logic w_found;

    always_comb begin
        winner  = '0;
        any     = |req;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = sel_t'(last + sel_t'(i));
            if (!w_found && req[w_idx]) begin
                winner  = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing a registered 4:1 mux select with
// valid/ready handshake and a post-accept hold window.
module rr_sel_arbiter
    import mux_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              sel_ready,
    output logic [1:0]        sel,
    output logic              sel_valid,
    output logic [NUM_CH-1:0] grant,
    output logic              busy
);

    localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

    arb_state_t        r_state;
    sel_t              r_sel;
    sel_t              r_last;
    logic [7:0]        r_cnt;
    logic              r_valid;
    logic              r_busy;
    logic [NUM_CH-1:0] r_grant;

    sel_t w_winner;
    logic w_any;

    rr_pick u_pick (
        .req    (req),
        .last   (r_last),
        .winner (w_winner),
        .any    (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_grant <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_winner;
                        r_grant <= NUM_CH'(1) << w_winner;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    // offer is never retracted; only the handshake ends it
                    if (sel_ready) begin
                        r_last  <= r_sel;
                        r_cnt   <= HOLD_M1;
                        r_valid <= 1'b0;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == 8'd0) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign sel       = r_sel;
    assign sel_valid = r_valid;
    assign grant     = r_grant;
    assign busy      = r_busy;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: directed scenarios plus random traffic,
// both checked against a cycle model built from the arbitration rules.
module tb_rr_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_ready;
    logic [3:0] req;

    logic [1:0] s0, s1;
    logic       v0, v1, b0, b1;
    logic [3:0] g0, g1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int hs0_cyc[$];
    int hs0_sel[$];
    int hs1_cyc[$];
    int hs1_sel[$];

    // model: mode 0 = waiting, 1 = offering, 2 = holding
    int m_mode[2];
    int m_sel[2];
    int m_last[2];
    int m_left[2];

    always #5 clk = ~clk;

    rr_sel_arbiter #(.HOLD_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .req(req), .sel_ready(sel_ready),
        .sel(s0), .sel_valid(v0), .grant(g0), .busy(b0)
    );

    rr_sel_arbiter #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .sel_ready(sel_ready),
        .sel(s1), .sel_valid(v1), .grant(g1), .busy(b1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic model_upd(input int k, input int hold);
        if (rst) begin
            m_mode[k] = 0;
            m_sel[k]  = 0;
            m_last[k] = 3;
            m_left[k] = 0;
        end else if (m_mode[k] == 0) begin
            if (req != 4'd0) begin
                for (int j = 1; j <= 4; j++) begin
                    int c;
                    c = (m_last[k] + j) % 4;
                    if (req[c]) begin
                        m_sel[k] = c;
                        break;
                    end
                end
                m_mode[k] = 1;
            end
        end else if (m_mode[k] == 1) begin
            if (sel_ready) begin
                m_last[k] = m_sel[k];
                m_left[k] = hold;
                m_mode[k] = 2;
            end
        end else begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) m_mode[k] = 0;
        end
    endtask

    task automatic model_chk(input int k, input int s, input int v,
                             input int g, input int b);
        int eb;
        int eg;
        eb = (m_mode[k] != 0) ? 1 : 0;
        eg = eb ? (1 << m_sel[k]) : 0;
        chk($sformatf("m%0d_valid", k), v, (m_mode[k] == 1) ? 1 : 0);
        chk($sformatf("m%0d_busy", k), b, eb);
        chk($sformatf("m%0d_grant", k), g, eg);
        chk($sformatf("m%0d_sel", k), s, m_sel[k]);
    endtask

    task automatic step();
        bit h0;
        bit h1;
        h0 = v0 && sel_ready && !rst;
        h1 = v1 && sel_ready && !rst;
        @(posedge clk);
        cyc++;
        if (h0) begin
            hs0_cyc.push_back(cyc);
            hs0_sel.push_back(int'(s0));
        end
        if (h1) begin
            hs1_cyc.push_back(cyc);
            hs1_sel.push_back(int'(s1));
        end
        model_upd(0, 4);
        model_upd(1, 1);
        @(negedge clk);
        model_chk(0, int'(s0), int'(v0), int'(g0), int'(b0));
        model_chk(1, int'(s1), int'(v1), int'(g1), int'(b1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        hs0_cyc.delete();
        hs0_sel.delete();
        hs1_cyc.delete();
        hs1_sel.delete();
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        req       = 4'd0;
        sel_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_sel[k]  = 0;
            m_last[k] = 3;
            m_left[k] = 0;
        end
        @(negedge clk);
        do_reset();
        chk("rst_valid", int'(v0), 0);
        chk("rst_busy", int'(b0), 0);
        chk("rst_grant", int'(g0), 0);
        chk("rst_sel", int'(s0), 0);

        // idle with no requests stays quiet
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_quiet", int'({v0, b0, g0}), 0);
        end

        // full request set rotates 0,1,2,3,0 every 6 cycles
        do_reset();
        req       = 4'b1111;
        sel_ready = 1'b1;
        for (int i = 0; i < 28; i++) step();
        chk("rot_count", hs0_sel.size() >= 5 ? 1 : 0, 1);
        if (hs0_sel.size() >= 5) begin
            for (int i = 0; i < 5; i++)
                chk($sformatf("rot_sel%0d", i), hs0_sel[i], i % 4);
            for (int i = 1; i < 5; i++)
                chk($sformatf("rot_gap%0d", i),
                    hs0_cyc[i] - hs0_cyc[i-1], 6);
        end

        // offer held while ready is low, even if the request drops
        do_reset();
        req       = 4'b0100;
        sel_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) req = 4'b0000;
            step();
            chk("offer_valid", int'(v0), 1);
            chk("offer_sel", int'(s0), 2);
        end
        sel_ready = 1'b1;
        step();
        chk("offer_hs", hs0_sel.size(), 1);

        // after ch3 wins, 1001 wraps round to ch0
        do_reset();
        req       = 4'b1000;
        sel_ready = 1'b1;
        step();
        step();
        chk("wrap_first", hs0_sel.size() == 1 ? hs0_sel[0] : -1, 3);
        req = 4'b1001;
        n   = 0;
        while (hs0_sel.size() < 2 && n < 20) begin
            step();
            n++;
        end
        chk("wrap_next", hs0_sel.size() == 2 ? hs0_sel[1] : -1, 0);

        // reset during hold aborts and restores ch0 priority
        do_reset();
        req       = 4'b0011;
        sel_ready = 1'b1;
        step();
        step();
        chk("abort_hs", hs0_sel.size(), 1);
        step();
        rst = 1'b1;
        step();
        chk("abort_busy", int'(b0), 0);
        chk("abort_grant", int'(g0), 0);
        chk("abort_valid", int'(v0), 0);
        rst = 1'b0;
        hs0_sel.delete();
        hs0_cyc.delete();
        n = 0;
        while (hs0_sel.size() < 1 && n < 20) begin
            step();
            n++;
        end
        chk("abort_next", hs0_sel.size() == 1 ? hs0_sel[0] : -1, 0);

        // ready outside offer is ignored; hold of 1 gives 3-cycle spacing
        do_reset();
        req       = 4'b0000;
        sel_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("ign_idle", hs1_sel.size(), 0);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) step();
        chk("h1_count", hs1_sel.size() >= 3 ? 1 : 0, 1);
        if (hs1_sel.size() >= 3) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("h1_sel%0d", i), hs1_sel[i], i);
            for (int i = 1; i < 3; i++)
                chk($sformatf("h1_gap%0d", i),
                    hs1_cyc[i] - hs1_cyc[i-1], 3);
        end

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req       = 4'($urandom);
            sel_ready = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 40) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_sel_arbiter.md
RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, is the number of cycles a granted select stays held after handshake; legal range 1..255.
REQ-002 clk  input  1  is the single clock, and all state updates on its rising edge.
REQ-003 rst  input  1  is a synchronous, active-high reset.
REQ-004 req  input  4  carries per-channel requests, one bit per 4:1 mux data input (bit i corresponds to d[i]).
REQ-005 sel_ready  input  1  is asserted by the downstream mux consumer when it accepts the offered select.
REQ-006 sel  output  2  is the registered select value for the downstream 4:1 mux s input.
REQ-007 sel_valid  output  1  indicates that sel is being offered for handshake.
REQ-008 grant  output  4  is the registered one-hot copy of sel, nonzero only in OFFER or HOLD.
REQ-009 busy  output  1  is high in OFFER and HOLD.

Function
REQ-010 The FSM SHALL have exactly three states, IDLE, OFFER and HOLD, encoded as a 2-bit enum.
REQ-011 In IDLE with req != 0, the block SHALL compute the winner as the first set req bit searching upward from (last+1) mod 4 with wrap, register it into sel, and enter OFFER on the next edge.
REQ-012 In IDLE with req == 0, the block SHALL remain in IDLE with sel unchanged and sel_valid=0.
REQ-013 Latency from req sampled in IDLE to sel_valid=1 SHALL be exactly 1 cycle.
REQ-014 In OFFER, sel_valid SHALL be 1, and sel and grant SHALL be stable until the handshake completes.
REQ-015 A handshake SHALL occur on any edge where sel_valid=1 and sel_ready=1; on it, last <= sel, hold counter <= HOLD_CYCLES-1, and state <= HOLD.
REQ-016 In OFFER, deassertion of the granted req bit SHALL NOT withdraw the offer (no retraction).
REQ-017 In HOLD, sel_valid SHALL be 0, sel and grant SHALL stay at the accepted value, and the counter SHALL decrement by 1 per cycle.
REQ-018 In HOLD with counter == 0, the next state SHALL be IDLE, and grant SHALL clear on the same edge.
REQ-019 Consequently, the minimum spacing between two handshakes SHALL be HOLD_CYCLES + 2 cycles.
REQ-020 sel_ready while not in OFFER SHALL be ignored.
REQ-021 With a single requester, that channel SHALL win every arbitration regardless of last.
REQ-022 Wrap-around: last=3 SHALL search order 0,1,2,3, and last=2 SHALL search order 3,0,1,2.
REQ-023 The hold counter SHALL be 8 bits wide and SHALL never underflow.

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL enter IDLE with sel=0, sel_valid=0, grant=0, busy=0, counter=0 and last=3, so that channel 0 has first priority.
REQ-025 Reset asserted mid-OFFER or mid-HOLD SHALL abort the transaction with no handshake, and outputs SHALL take reset values on that edge.
REQ-026 Reset SHALL take priority over a simultaneous handshake.

Structure
REQ-027 A shared package mux_pkg SHALL hold the sel_t (logic [1:0]) typedef, the state enum arb_state_t, and the constant NUM_CH=4.
REQ-028 The rotating priority search SHALL be a combinational sub-module rr_pick with inputs req[3:0] and last[1:0], and outputs winner[1:0] and any.
REQ-029 The block SHALL contain no latches, and all outputs SHALL be driven directly from flops.

Verification
REQ-030 Reset with req=4'b1111, then sel_ready tied 1 and HOLD_CYCLES=4: the bench SHALL observe handshakes on sel=0,1,2,3,0, each spaced 6 cycles apart.
REQ-031 req=4'b0100 only, with sel_ready=0 for 5 cycles: sel_valid=1 and sel=2 SHALL stay stable for all 5 cycles, and dropping req[2] mid-wait SHALL leave the offer intact.
REQ-032 After a grant to ch3, req=4'b1001: the next grant SHALL be sel=0, the wrap-around case.
REQ-033 Assert rst during HOLD at counter=2: on the next edge the bench SHALL see state IDLE, grant=0, busy=0, and the next grant for req=4'b0011 SHALL be sel=0.
REQ-034 Pulse sel_ready=1 during IDLE and HOLD with HOLD_CYCLES=1: no handshake SHALL occur and last SHALL be unchanged; a handshake occurring in OFFER SHALL give 3-cycle spacing.
REQ-035 With req=0 for 20 cycles after reset: sel_valid, busy and grant SHALL all remain 0.
